// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares the single write port of a FIFO among
// N_REQ requesters. A grant is burst-locked: it is held until the granted
// requester's last beat is written, or until MAX_BURST beats have been
// written (MAX_BURST = 0 means release on last only). There is one idle
// cycle between consecutive bursts.
//
// Ports
//   wclk        write-side clock
//   rrst        asynchronous, active-high reset
//   req_valid   per-requester beat valid
//   req_data    requester i data at [i*WIDTH +: WIDTH]
//   req_last    final beat of the requester's packet
//   req_ready   beat accepted when req_valid[i] & req_ready[i]
//   grant       one-hot registered grant, all-zero when idle
//   busy        high while a burst is in progress
//   fifo_wdata  FIFO write data (0 when idle)
//   fifo_we     FIFO write enable
//   fifo_wfull  FIFO full flag
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no grant; pick next requester from rr_ptr
// XFER  | grant locked to one requester, beats flowing

module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                   wclk,
  input  logic                   rrst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [WIDTH-1:0]       fifo_wdata,
  output logic                   fifo_we,
  input  logic                   fifo_wfull
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCW  = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BCW-1:0] LIMIT_M1 = BCW'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  gidx_q, gidx_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

  logic             pick_found;
  logic [IDXW-1:0]  pick_idx;
  logic [IDXW-1:0]  cand;
  logic             cur_valid;
  logic             cur_last;
  logic             accept;
  logic             limit_hit;
  logic             burst_end;

  // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDXW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // grant_q is one-hot, so masking selects the granted requester's bits.
  assign cur_valid = |(req_valid & grant_q);
  assign cur_last  = |(req_last & grant_q);
  assign busy      = (state_q == XFER);
  assign accept    = busy & cur_valid & ~fifo_wfull;
  assign limit_hit = (MAX_BURST != 0) && (beat_cnt_q == LIMIT_M1);
  assign burst_end = accept & (cur_last | limit_hit);

  assign fifo_we   = accept;
  assign grant     = grant_q;
  assign req_ready = grant_q & {N_REQ{busy & ~fifo_wfull}};

  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (busy && gidx_q == IDXW'(i)) fifo_wdata = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d           = XFER;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          beat_cnt_d        = '0;
        end
      end
      XFER: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (burst_end) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == IDXW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge rrst) begin
    if (rrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are compared
// 3 time units after the edge, well before the next one.

module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        rrst;
  logic [3:0]  vld;
  logic [3:0]  lst;
  logic [7:0]  d [4];
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  fifo_wdata;
  logic        fifo_we;
  logic        wfull;

  int n_chk;
  int n_bad;
  int wr_cnt;
  int w0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .wclk       (wclk),
    .rrst       (rrst),
    .req_valid  (vld),
    .req_data   (req_data),
    .req_last   (lst),
    .req_ready  (req_ready),
    .grant      (grant),
    .busy       (busy),
    .fifo_wdata (fifo_wdata),
    .fifo_we    (fifo_we),
    .fifo_wfull (wfull)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(posedge wclk) if (fifo_we) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_bad = 0; wr_cnt = 0;
    rrst = 1'b0; vld = '0; lst = '0; wfull = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // async reset, no clock edge yet
    #1 rrst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we", 32'(fifo_we), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wdata", 32'(fifo_wdata), 32'h0);
    step(); step();
    chk("rst_hold_grant", 32'(grant), 32'h0);
    #3 rrst = 1'b0;
    step();

    // single burst: requester 1, beats A1,B2,C3
    w0 = wr_cnt;
    vld = 4'b0010; d[1] = 8'hA1; lst = '0;
    #2;
    chk("s1_idle_grant", 32'(grant), 32'h0);
    chk("s1_idle_we", 32'(fifo_we), 32'h0);
    step(); #2;
    chk("s1_b1_grant", 32'(grant), 32'h2);
    chk("s1_b1_busy", 32'(busy), 32'h1);
    chk("s1_b1_ready", 32'(req_ready), 32'h2);
    chk("s1_b1_we", 32'(fifo_we), 32'h1);
    chk("s1_b1_data", 32'(fifo_wdata), 32'hA1);
    step(); d[1] = 8'hB2; #2;
    chk("s1_b2_we", 32'(fifo_we), 32'h1);
    chk("s1_b2_data", 32'(fifo_wdata), 32'hB2);
    step(); d[1] = 8'hC3; lst[1] = 1'b1; #2;
    chk("s1_b3_we", 32'(fifo_we), 32'h1);
    chk("s1_b3_data", 32'(fifo_wdata), 32'hC3);
    step(); vld = '0; lst = '0; #2;
    chk("s1_end_busy", 32'(busy), 32'h0);
    chk("s1_end_grant", 32'(grant), 32'h0);
    chk("s1_end_wdata", 32'(fifo_wdata), 32'h0);
    chk("s1_writes", 32'(wr_cnt - w0), 32'd3);

    // fairness from rr_ptr=0: all valid, 1-beat packets
    rrst = 1'b1; #1 rrst = 1'b0;
    step();
    vld = 4'b1111; lst = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (k % 4);
      #2;
      chk("fair_idle_busy", 32'(busy), 32'h0);
      chk("fair_idle_grant", 32'(grant), 32'h0);
      step(); #2;
      chk("fair_grant", 32'(grant), 32'(eg));
      chk("fair_we", 32'(fifo_we), 32'h1);
      chk("fair_data", 32'(fifo_wdata), 32'h10 + 32'(k % 4));
      step();
    end
    vld = '0; lst = '0; #2;
    chk("fair_end_busy", 32'(busy), 32'h0);
    step(); #2;
    chk("fair_quiet_busy", 32'(busy), 32'h0);

    // backpressure: requester 2, 4 beats, full for 3 cycles after beat 2
    w0 = wr_cnt;
    vld = 4'b0100; d[2] = 8'h30;
    #2; step(); #2;
    chk("bp_b1_we", 32'(fifo_we), 32'h1);
    chk("bp_b1_data", 32'(fifo_wdata), 32'h30);
    step(); d[2] = 8'h31; #2;
    chk("bp_b2_we", 32'(fifo_we), 32'h1);
    chk("bp_b2_data", 32'(fifo_wdata), 32'h31);
    step(); wfull = 1'b1; d[2] = 8'h32;
    for (int s = 0; s < 3; s++) begin
      #2;
      chk("bp_stall_we", 32'(fifo_we), 32'h0);
      chk("bp_stall_ready", 32'(req_ready), 32'h0);
      chk("bp_stall_grant", 32'(grant), 32'h4);
      chk("bp_stall_busy", 32'(busy), 32'h1);
      step();
    end
    wfull = 1'b0; #2;
    chk("bp_b3_we", 32'(fifo_we), 32'h1);
    chk("bp_b3_data", 32'(fifo_wdata), 32'h32);
    chk("bp_b3_ready", 32'(req_ready), 32'h4);
    step(); d[2] = 8'h33; lst[2] = 1'b1; #2;
    chk("bp_b4_we", 32'(fifo_we), 32'h1);
    chk("bp_b4_data", 32'(fifo_wdata), 32'h33);
    step(); vld = '0; lst = '0; #2;
    chk("bp_end_busy", 32'(busy), 32'h0);
    chk("bp_writes", 32'(wr_cnt - w0), 32'd4);

    // burst limit: requester 0 streams without last, requester 2 waiting
    vld = 4'b0101; lst = 4'b0100; d[0] = 8'h40; d[2] = 8'h55;
    #2;
    chk("lim_idle_grant", 32'(grant), 32'h0);
    step();
    w0 = wr_cnt;
    for (int n = 0; n < 4; n++) begin
      d[0] = 8'h40 + 8'(n);
      #2;
      chk("lim_grant0", 32'(grant), 32'h1);
      chk("lim_we", 32'(fifo_we), 32'h1);
      chk("lim_data", 32'(fifo_wdata), 32'h40 + 32'(n));
      step();
    end
    d[0] = 8'h44; #2;
    chk("lim_release_busy", 32'(busy), 32'h0);
    chk("lim_release_grant", 32'(grant), 32'h0);
    chk("lim_writes0", 32'(wr_cnt - w0), 32'd4);
    step(); #2;
    chk("lim_grant2", 32'(grant), 32'h4);
    chk("lim_data2", 32'(fifo_wdata), 32'h55);
    step(); vld = '0; lst = '0; #2;
    chk("lim_end_busy", 32'(busy), 32'h0);

    // reset mid-burst
    vld = 4'b0010; d[1] = 8'h77;
    #2; step(); #2;
    chk("rmb_grant", 32'(grant), 32'h2);
    chk("rmb_busy", 32'(busy), 32'h1);
    rrst = 1'b1; vld = 4'b1001; d[0] = 8'h88; d[3] = 8'h99;
    #1;
    chk("rmb_we", 32'(fifo_we), 32'h0);
    chk("rmb_grant0", 32'(grant), 32'h0);
    chk("rmb_busy0", 32'(busy), 32'h0);
    chk("rmb_ready0", 32'(req_ready), 32'h0);
    rrst = 1'b0;
    step(); lst = 4'b0001; #2;
    chk("rmb_regrant", 32'(grant), 32'h1);
    chk("rmb_data", 32'(fifo_wdata), 32'h88);
    chk("rmb_we1", 32'(fifo_we), 32'h1);
    step(); vld = '0; lst = '0; #2;
    chk("rmb_end_busy", 32'(busy), 32'h0);

    // wrap-around: burst from requester 3, then 0 and 2 compete
    vld = 4'b1000; lst = 4'b1000; d[3] = 8'h66;
    #2; step(); #2;
    chk("wrap_grant3", 32'(grant), 32'h8);
    chk("wrap_data3", 32'(fifo_wdata), 32'h66);
    step(); vld = 4'b0101; lst = 4'b0101; d[0] = 8'h70; d[2] = 8'h72; #2;
    chk("wrap_idle_busy", 32'(busy), 32'h0);
    step(); #2;
    chk("wrap_grant0", 32'(grant), 32'h1);
    chk("wrap_data0", 32'(fifo_wdata), 32'h70);
    step(); vld = '0; lst = '0; #2;
    chk("wrap_end_busy", 32'(busy), 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
